// File: rtl/inst_fetch_resp_pkg.sv
// Shared types and constants for the instruction-fetch responder:
// address/instruction buses, the NOP returned for out-of-range fetches,
// and the 2-bit fetch FSM state encoding.
package inst_fetch_resp_pkg;

  typedef logic [31:0] InstAddrBus;
  typedef logic [31:0] InstBus;

  localparam InstBus NOP_INST = 32'h00000013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_resp_mem.sv
// inst_mem_array: DEPTH x 32 instruction store with one synchronous write
// port and one synchronous read port. A read and a write to the same word
// on the same edge return the word as it was before the write.
// The array itself is never cleared; only the read-data register resets.
module inst_mem_array
  import inst_fetch_resp_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  InstBus mem [DEPTH];

  // Program-load write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register samples the pre-write contents on a same-edge collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/inst_fetch_resp.sv
// inst_fetch_resp: responder end of the instruction-fetch interface.
// Grants requests in IDLE or RESP, waits WAIT_CYCLES cycles, then pulses
// inst_valid_o for one cycle with the fetched word. Out-of-range fetches
// return a NOP; a flush squashes the pending fetch.
// Optional feature: define MISALIGN_CHK_EN to flag fetches whose low two
// address bits are non-zero (inst_o=0, inst_err_o=1).
module inst_fetch_resp
  import inst_fetch_resp_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req_i,
  input  logic [31:0] fetch_addr_i,
  output logic        fetch_gnt_o,
  input  logic        flush_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic        inst_err_o,
  input  logic        load_we_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_data_i
);

  localparam int         AW        = $clog2(DEPTH);
  localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_INIT  = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  fetch_state_e  state;
  logic [3:0]    wait_cnt;
  InstAddrBus    addr_q;
  InstAddrBus    rd_addr;
  logic          rd_en;
  logic          rd_in_range;
  logic          wr_in_range;
  logic          range_err_q;
  InstBus        mem_rdata;
  logic          unused_addr_bits;

  assign fetch_gnt_o  = fetch_req_i & ~flush_i & ((state == ST_IDLE) | (state == ST_RESP));
  assign inst_valid_o = (state == ST_RESP) & ~flush_i;

  // While waiting the captured address is used; a zero-wait build reads
  // straight from the request address on the grant edge.
  assign rd_addr     = (state == ST_WAIT) ? addr_q : fetch_addr_i;
  assign rd_en       = ~flush_i & (((state == ST_WAIT) & (wait_cnt == 4'd0)) |
                                   (fetch_gnt_o & ZERO_WAIT));
  assign rd_in_range = (rd_addr >> (AW + 2)) == 32'd0;
  assign wr_in_range = (load_addr_i >> (AW + 2)) == 32'd0;

  assign unused_addr_bits = ^{rd_addr[1:0], load_addr_i[1:0]};

  inst_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (load_we_i & wr_in_range),
    .waddr (load_addr_i[AW+1:2]),
    .wdata (load_data_i),
    .re    (rd_en),
    .raddr (rd_addr[AW+1:2]),
    .rdata (mem_rdata)
  );

  // Fetch FSM: flush beats any request, a grant (re)starts the wait count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      addr_q   <= '0;
    end else if (flush_i) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
    end else if (fetch_gnt_o) begin
      addr_q   <= fetch_addr_i;
      wait_cnt <= CNT_INIT;
      state    <= ZERO_WAIT ? ST_RESP : ST_WAIT;
    end else begin
      case (state)
        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Out-of-range flag is captured alongside the memory read so it lines up with the data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      range_err_q <= 1'b0;
    end else if (rd_en) begin
      range_err_q <= ~rd_in_range;
    end
  end

`ifdef MISALIGN_CHK_EN
  logic misalign_q;

  // Misalignment flag is captured with the read so the error lands with inst_valid_o.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_q <= 1'b0;
    end else if (rd_en) begin
      misalign_q <= (rd_addr[1:0] != 2'b00);
    end
  end

  assign inst_o     = misalign_q ? 32'h0 : (range_err_q ? NOP_INST : mem_rdata);
  assign inst_err_o = misalign_q;
`else
  assign inst_o     = range_err_q ? NOP_INST : mem_rdata;
  assign inst_err_o = 1'b0;
`endif

endmodule
